// File: rtl/sprite_pkg.sv
// Shared types for the sprite overlay: loader states, byte lanes,
// RGB888 word type and sizing helpers.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } ld_state_t;

  localparam logic [1:0] LANE_R = 2'd0;
  localparam logic [1:0] LANE_G = 2'd1;
  localparam logic [1:0] LANE_B = 2'd2;

  typedef logic [23:0] rgb888_t;

  function automatic int npix(input int w, input int h);
    return w * h;
  endfunction

  function automatic int addr_w(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage

// File: rtl/sprite_ram.sv
// Sprite store: simple dual-port RAM, per-byte write enable,
// registered read with one cycle of latency.
module sprite_ram
  import sprite_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          iCLK,
  input  logic          we,
  input  logic [2:0]    be,
  input  logic [AW-1:0] wr_addr,
  input  rgb888_t       wr_data,
  input  logic [AW-1:0] rd_addr,
  output rgb888_t       rd_data
);

  rgb888_t mem [DEPTH];

  always_ff @(posedge iCLK) begin
    if (we) begin
      if (be[LANE_R]) mem[wr_addr][23:16] <= wr_data[23:16];
      if (be[LANE_G]) mem[wr_addr][15:8]  <= wr_data[15:8];
      if (be[LANE_B]) mem[wr_addr][7:0]   <= wr_data[7:0];
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sprite_overlay.sv
// Composites a byte-loaded RGB888 sprite over the camera stream.
// Define SPRITE_COLORKEY_EN to make KEY_RGB sprite pixels transparent.
module sprite_overlay
  import sprite_pkg::*;
#(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter int          WIDTH    = 16,
  parameter int          HEIGHT   = 16,
  parameter int          CDW      = 12,
  parameter logic [23:0] KEY_RGB  = 24'hFF00FF
) (
  input  logic           iCLK,
  input  logic           iRST,
  input  logic [10:0]    iX_Cont,
  input  logic [10:0]    iY_Cont,
  input  logic [CDW-1:0] iRed,
  input  logic [CDW-1:0] iGreen,
  input  logic [CDW-1:0] iBlue,
  input  logic           iDVAL,
  input  logic [10:0]    iPOS_X,
  input  logic [10:0]    iPOS_Y,
  input  logic           iLD_START,
  input  logic           iLD_VALID,
  input  logic [7:0]     iLD_DATA,
  output logic           oLD_DONE,
  output logic [CDW-1:0] oRed,
  output logic [CDW-1:0] oGreen,
  output logic [CDW-1:0] oBlue,
  output logic           oDVAL
);

  localparam int NPIX = npix(WIDTH, HEIGHT);
  localparam int AW   = addr_w(WIDTH, HEIGHT);
  localparam logic [10:0] POS_X0 = 11'((H_ACTIVE - WIDTH) / 2);
  localparam logic [10:0] POS_Y0 = 11'((V_ACTIVE - HEIGHT) / 2);
`ifdef SPRITE_COLORKEY_EN
  localparam logic KEY_EN = 1'b1;
`else
  localparam logic KEY_EN = 1'b0;
`endif

  ld_state_t     state, state_nx;
  logic [AW-1:0] pix_idx;
  logic [1:0]    byte_off;
  logic          ld_we;
  logic          last_byte;
  logic [2:0]    ld_be;

  assign last_byte = (pix_idx == AW'(NPIX - 1)) && (byte_off == LANE_B);
  assign ld_be     = 3'b001 << byte_off;
  assign oLD_DONE  = (state == READY);

  always_comb begin
    state_nx = state;
    ld_we    = 1'b0;
    if (iLD_START) begin
      state_nx = LOAD;
    end else begin
      unique case (state)
        IDLE:  state_nx = IDLE;
        LOAD: begin
          if (iLD_VALID) begin
            ld_we = 1'b1;
            if (last_byte) state_nx = READY;
          end
        end
        READY: state_nx = READY;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= IDLE;
      pix_idx  <= '0;
      byte_off <= LANE_R;
    end else begin
      state <= state_nx;
      if (iLD_START) begin
        pix_idx  <= '0;
        byte_off <= LANE_R;
      end else if (ld_we) begin
        if (byte_off == LANE_B) begin
          byte_off <= LANE_R;
          pix_idx  <= pix_idx + 1'b1;
        end else begin
          byte_off <= byte_off + 2'd1;
        end
      end
    end
  end

  // The frame-start pixel already uses the newly requested position.
  logic        frame_start;
  logic [10:0] posx_r, posy_r;
  logic [10:0] pos_x, pos_y;

  assign frame_start = iDVAL && (iX_Cont == 11'd0) && (iY_Cont == 11'd0);
  assign pos_x = frame_start ? iPOS_X : posx_r;
  assign pos_y = frame_start ? iPOS_Y : posy_r;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      posx_r <= POS_X0;
      posy_r <= POS_Y0;
    end else if (frame_start) begin
      posx_r <= iPOS_X;
      posy_r <= iPOS_Y;
    end
  end

  logic [11:0]   x12, y12, px12, py12;
  logic          hit;
  logic [10:0]   dx, dy;
  logic [AW-1:0] rd_addr;
  rgb888_t       rd_data;

  assign x12  = {1'b0, iX_Cont};
  assign y12  = {1'b0, iY_Cont};
  assign px12 = {1'b0, pos_x};
  assign py12 = {1'b0, pos_y};
  assign hit  = oLD_DONE && iDVAL
             && (x12 >= px12) && (x12 < px12 + 12'(WIDTH))
             && (y12 >= py12) && (y12 < py12 + 12'(HEIGHT));
  assign dx = iX_Cont - pos_x;
  assign dy = iY_Cont - pos_y;
  assign rd_addr = AW'(32'(dy) * 32'(WIDTH) + 32'(dx));

  sprite_ram #(
    .DEPTH(NPIX),
    .AW   (AW)
  ) u_ram (
    .iCLK   (iCLK),
    .we     (ld_we),
    .be     (ld_be),
    .wr_addr(pix_idx),
    .wr_data({3{iLD_DATA}}),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  logic           hit_s1, dval_s1;
  logic [CDW-1:0] bg_r_s1, bg_g_s1, bg_b_s1;
  logic           sel_spr;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      hit_s1  <= 1'b0;
      dval_s1 <= 1'b0;
      bg_r_s1 <= '0;
      bg_g_s1 <= '0;
      bg_b_s1 <= '0;
    end else begin
      hit_s1  <= hit;
      dval_s1 <= iDVAL;
      bg_r_s1 <= iRed;
      bg_g_s1 <= iGreen;
      bg_b_s1 <= iBlue;
    end
  end

  function automatic logic [CDW-1:0] widen(input logic [7:0] b);
    return CDW'(b) << (CDW - 8);
  endfunction

  assign sel_spr = hit_s1 && !(KEY_EN && (rd_data == KEY_RGB));

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oRed   <= '0;
      oGreen <= '0;
      oBlue  <= '0;
      oDVAL  <= 1'b0;
    end else begin
      oDVAL <= dval_s1;
      if (sel_spr) begin
        oRed   <= widen(rd_data[23:16]);
        oGreen <= widen(rd_data[15:8]);
        oBlue  <= widen(rd_data[7:0]);
      end else begin
        oRed   <= bg_r_s1;
        oGreen <= bg_g_s1;
        oBlue  <= bg_b_s1;
      end
    end
  end

endmodule
